dbg_tx_formatter: RTL



---
 rtl/dbg_pkg.sv | 26 ++
 rtl/hex_nib2ascii.sv | 19 +
 rtl/dbg_tx_formatter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// Shared debug-path types and ASCII constants.
// Optional macro DBG_TX_HEX_PREFIX_EN adds the "0x" prefix state to the formatter FSM.
package dbg_pkg;

  localparam logic TYPE_CHAR = 1'b0;
  localparam logic TYPE_WORD = 1'b1;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_x  = 8'h78;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_HEX,
    ST_SEND_SEP,
    ST_SEND_CHAR,
    ST_ACK,
    ST_RELEASE
`ifdef DBG_TX_HEX_PREFIX_EN
    , ST_SEND_PFX
`endif
  } fmt_state_e;

endpackage

// File: rtl/hex_nib2ascii.sv
// Combinational nibble-to-ASCII hex digit encoder; also used by the RX echo path.
module hex_nib2ascii
  import dbg_pkg::*;
#(
  parameter bit LOWER_HEX = 1'b0
) (
  input  logic [3:0] i_nib,
  output logic [7:0] o_asc
);

  // Letter base is the ASCII code of 'A'/'a' minus 10, so nibble 10 lands on the letter.
  localparam logic [7:0] ALPHA_BASE = LOWER_HEX ? 8'h57 : 8'h37;

  always_comb begin
    if (i_nib < 4'd10) o_asc = CH_0 + {4'h0, i_nib};
    else               o_asc = ALPHA_BASE + {4'h0, i_nib};
  end

endmodule

// File: rtl/dbg_tx_formatter.sv
// Formats debug handler transmit requests as ASCII hex words or raw chars for the UART.
// Optional macro DBG_TX_HEX_PREFIX_EN: emit "0x" before every hex word.
module dbg_tx_formatter
  import dbg_pkg::*;
#(
  parameter logic [7:0] SEP_CHAR  = 8'h20,
  parameter bit         LOWER_HEX = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_tx,
  input  logic        type_tx,
  input  logic [31:0] dout,
  output logic        ack_tx,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  fmt_state_e  r_state, w_state_nxt;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [31:0] r_data;
  logic [7:0]  r_tx_data, w_tx_data;
  logic        r_tx_valid, w_tx_valid;
  logic        r_ack, w_ack;
  logic        r_busy, w_busy;
  logic        w_xfer;
  logic [3:0]  w_nib;
  logic [7:0]  w_asc;

  assign w_xfer = r_tx_valid & tx_ready;

  // Nibble for the byte presented after this edge: MSB nibble at idx 0.
  assign w_nib = r_data[{~w_idx_nxt, 2'b00} +: 4];

  hex_nib2ascii #(.LOWER_HEX(LOWER_HEX)) u_nib2asc (
    .i_nib (w_nib),
    .o_asc (w_asc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= 3'd0;
      r_data  <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (r_state == ST_IDLE && req_tx) r_data <= dout;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        w_idx_nxt = 3'd0;
        if (req_tx) begin
`ifdef DBG_TX_HEX_PREFIX_EN
          w_state_nxt = (type_tx == TYPE_WORD) ? ST_SEND_PFX : ST_SEND_CHAR;
`else
          w_state_nxt = (type_tx == TYPE_WORD) ? ST_SEND_HEX : ST_SEND_CHAR;
`endif
        end
      end
`ifdef DBG_TX_HEX_PREFIX_EN
      ST_SEND_PFX: if (w_xfer) begin
        if (r_idx == 3'd1) begin
          w_state_nxt = ST_SEND_HEX;
          w_idx_nxt   = 3'd0;
        end else begin
          w_idx_nxt   = r_idx + 3'd1;
        end
      end
`endif
      ST_SEND_HEX: if (w_xfer) begin
        if (r_idx == 3'd7) begin
          w_state_nxt = ST_SEND_SEP;
          w_idx_nxt   = 3'd0;
        end else begin
          w_idx_nxt   = r_idx + 3'd1;
        end
      end
      ST_SEND_SEP:  if (w_xfer) w_state_nxt = ST_ACK;
      ST_SEND_CHAR: if (w_xfer) w_state_nxt = ST_ACK;
      ST_ACK:       w_state_nxt = ST_RELEASE;
      ST_RELEASE:   if (!req_tx) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs track the post-edge state, except the IDLE exit which gives the
  // payload latch a cycle before the first byte goes out.
  always_comb begin
    w_tx_valid = 1'b0;
    w_tx_data  = r_tx_data;
    w_ack      = (r_state == ST_ACK);
    w_busy     = (w_state_nxt != ST_IDLE);
    if (r_state != ST_IDLE) begin
      case (w_state_nxt)
`ifdef DBG_TX_HEX_PREFIX_EN
        ST_SEND_PFX: begin
          w_tx_valid = 1'b1;
          w_tx_data  = w_idx_nxt[0] ? CH_x : CH_0;
        end
`endif
        ST_SEND_HEX: begin
          w_tx_valid = 1'b1;
          w_tx_data  = w_asc;
        end
        ST_SEND_SEP: begin
          w_tx_valid = 1'b1;
          w_tx_data  = SEP_CHAR;
        end
        ST_SEND_CHAR: begin
          w_tx_valid = 1'b1;
          w_tx_data  = r_data[7:0];
        end
        default: w_tx_valid = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_tx_valid <= w_tx_valid;
      r_tx_data  <= w_tx_data;
      r_ack      <= w_ack;
      r_busy     <= w_busy;
    end
  end

  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign ack_tx   = r_ack;
  assign busy     = r_busy;

endmodule
